// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the math blocks (sqrt, log, LSM regression).
package fpga_cfg_pkg;

  localparam int FP_WIDTH       = 32;
  localparam int FP_QINT        = 15;
  localparam int FP_QFRAC       = 16;
  localparam int FP_MUL_LATENCY = 2;

  typedef logic signed [FP_WIDTH-1:0] fx_t;

endpackage

// File: rtl/fx_pipe_reg.sv
// Generic valid/data delay stage that advances with the shared pipeline enable.
module fx_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fx_mul.sv
// Pipelined signed fixed-point multiplier: round-half-up, saturated, valid/ready stream.
module fx_mul
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int QINT    = FP_QINT,
  parameter int QFRAC   = FP_QFRAC,
  parameter int LATENCY = FP_MUL_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] HALF  = PW'(1) << (QFRAC - 1);
  localparam logic signed [PW-1:0] MAX_V = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  if (WIDTH != 1 + QINT + QFRAC || QFRAC < 1 || LATENCY < 1) begin : g_bad_cfg
    $error("fx_mul: inconsistent WIDTH/QINT/QFRAC/LATENCY");
  end

  function automatic logic [WIDTH-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p + HALF;
    s = s >>> QFRAC;
    if (s > MAX_V) return MAX_V[WIDTH-1:0];
    if (s < MIN_V) return MIN_V[WIDTH-1:0];
    return s[WIDTH-1:0];
  endfunction

  logic                 adv;
  logic signed [PW-1:0] p_d;

  // The whole pipeline freezes while a finished result waits on downstream.
  assign adv       = ready_in | ~valid_out;
  assign ready_out = adv;
  assign p_d       = PW'($signed(a)) * PW'($signed(b));

  if (LATENCY == 1) begin : g_lat1
    logic             v_q;
    logic [WIDTH-1:0] r_q;

    // NOTE: non-blocking assignments make every stage sample pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= valid_in;
        if (valid_in) r_q <= round_sat(p_d);
      end
    end

    assign valid_out = v_q;
    assign result    = r_q;
  end else begin : g_latn
    logic                 v1_q, v2_q;
    logic signed [PW-1:0] p_q;
    logic [WIDTH-1:0]     r2_q;
    logic [LATENCY-2:0]   v_chain;
    logic [WIDTH-1:0]     d_chain [LATENCY-1];

    // NOTE: data registers are reset as well so result reads 0 right after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q <= 1'b0;
        p_q  <= '0;
        v2_q <= 1'b0;
        r2_q <= '0;
      end else if (adv) begin
        v1_q <= valid_in;
        if (valid_in) p_q <= p_d;
        v2_q <= v1_q;
        if (v1_q) r2_q <= round_sat(p_q);
      end
    end

    assign v_chain[0] = v2_q;
    assign d_chain[0] = r2_q;

    for (genvar i = 0; i < LATENCY - 2; i++) begin : g_dly
      fx_pipe_reg #(.W(WIDTH)) u_dly (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv),
        .valid_i (v_chain[i]),
        .data_i  (d_chain[i]),
        .valid_o (v_chain[i+1]),
        .data_o  (d_chain[i+1])
      );
    end

    assign valid_out = v_chain[LATENCY-2];
    assign result    = d_chain[LATENCY-2];
  end

endmodule

// File: tb/tb_fx_mul.sv
// Directed and scoreboarded bench for fx_mul: arithmetic, latency, backpressure, reset.
module tb_fx_mul;
  import fpga_cfg_pkg::*;

  localparam int W = FP_WIDTH;

  logic         clk = 1'b0;
  logic         rst, valid_in, ready_out, valid_out, ready_in;
  logic [W-1:0] a, b, result;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  fx_mul dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .a         (a),
    .b         (b),
    .result    (result)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p, q, maxv, minv;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    p = longint'($signed(x)) * longint'($signed(y));
    q = (p + (longint'(1) << (FP_QFRAC - 1))) >>> FP_QFRAC;
    if (q > maxv) q = maxv;
    if (q < minv) q = minv;
    return q[W-1:0];
  endfunction

  // One isolated transaction with hand-computed expectation and latency measurement.
  task automatic run_one(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic [W-1:0] exp);
    int cyc;
    @(negedge clk);
    valid_in = 1'b1; a = ai; b = bi; ready_in = 1'b1;
    #1 check({tag, "_rdy"}, W'(ready_out), W'(1));
    @(negedge clk);
    valid_in = 1'b0; a = '0; b = '0;
    check({tag, "_early"}, W'(valid_out), W'(0));
    cyc = 1;
    while (!valid_out && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, W'(cyc), W'(FP_MUL_LATENCY));
    check({tag, "_res"}, result, exp);
  endtask

  // One stream cycle: drive inputs, score any output transfer, model any input accept.
  task automatic cycle(input logic vin, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic rdy, input string tag, output logic accepted,
                       output logic popped);
    @(negedge clk);
    valid_in = vin; a = ai; b = bi; ready_in = rdy;
    #1;
    popped = 1'b0;
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) check({tag, "_extra"}, W'(valid_out), W'(0));
      else begin
        check(tag, result, exp_q.pop_front());
        popped = 1'b1;
      end
    end
    accepted = vin && ready_out;
    if (accepted) exp_q.push_back(ref_mul(ai, bi));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] sa [16];
    logic [W-1:0] sb [16];
    logic         acc, pop;
    int           in_i, outs, first, last;

    rst = 1'b1; valid_in = 1'b0; a = '0; b = '0; ready_in = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid_out", W'(valid_out), W'(0));
    check("rst_result", result, '0);
    check("rst_ready_out", W'(ready_out), W'(1));
    rst = 1'b0;

    run_one("mul_1p5x2",   32'h0001_8000, 32'h0002_0000, 32'h0003_0000);
    run_one("mul_m1p5x2",  32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000);
    run_one("half_up",     32'h0000_0001, 32'h0000_8000, 32'h0000_0001);
    run_one("neg_half_up", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000);
    run_one("below_half",  32'h0000_0001, 32'h0000_7FFF, 32'h0000_0000);
    run_one("sat_pos",     32'h7FFF_FFFF, 32'h0002_0000, 32'h7FFF_FFFF);
    run_one("sat_neg",     32'h8000_0000, 32'h0002_0000, 32'h8000_0000);
    run_one("min_x_min",   32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);

    // Full-throughput stream of 16 pairs, mixing saturating and in-range operands.
    for (int i = 0; i < 16; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      if (i % 2 == 0) begin
        sa[i] = $unsigned($signed(sa[i]) >>> 10);
        sb[i] = $unsigned($signed(sb[i]) >>> 12);
      end
    end
    in_i = 0; outs = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (in_i < 16) cycle(1'b1, sa[in_i], sb[in_i], 1'b1, "stream", acc, pop);
      else           cycle(1'b0, '0, '0, 1'b1, "stream", acc, pop);
      if (acc) in_i++;
      if (pop) begin
        if (first < 0) first = c;
        last = c;
        outs++;
      end
    end
    check("stream_count", W'(outs), W'(16));
    check("stream_back2back", W'(last - first), W'(15));

    // Backpressure: stall the output for 5 cycles while the sender keeps offering.
    for (int i = 0; i < 8; i++) begin
      sa[i] = $unsigned($signed(32'($urandom)) >>> 9);
      sb[i] = $unsigned($signed(32'($urandom)) >>> 11);
    end
    in_i = 0; outs = 0;
    repeat (3) begin
      cycle(1'b1, sa[in_i], sb[in_i], 1'b1, "bp", acc, pop);
      if (acc) in_i++;
      if (pop) outs++;
    end
    for (int s = 0; s < 5; s++) begin
      cycle(1'b1, sa[in_i], sb[in_i], 1'b0, "bp", acc, pop);
      if (acc) in_i++;
      check("bp_ready_out", W'(ready_out), W'(0));
      check("bp_valid_out", W'(valid_out), W'(1));
      if (exp_q.size() > 0) check("bp_result_hold", result, exp_q[0]);
      else                  check("bp_model_nonempty", W'(exp_q.size()), W'(1));
    end
    for (int c = 0; c < 30 && in_i < 8; c++) begin
      cycle(1'b1, sa[in_i], sb[in_i], 1'b1, "bp", acc, pop);
      if (acc) in_i++;
      if (pop) outs++;
    end
    repeat (6) begin
      cycle(1'b0, '0, '0, 1'b1, "bp", acc, pop);
      if (pop) outs++;
    end
    check("bp_outputs", W'(outs), W'(8));
    check("bp_drained", W'(exp_q.size()), W'(0));

    // Reset with two items in flight: nothing of them may come out afterwards.
    cycle(1'b1, 32'h0003_0000, 32'h0002_0000, 1'b1, "rst_fill", acc, pop);
    cycle(1'b1, 32'h0004_0000, 32'h0002_0000, 1'b1, "rst_fill", acc, pop);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; a = '0; b = '0;
    @(negedge clk);
    check("midrst_valid_out", W'(valid_out), W'(0));
    check("midrst_result", result, '0);
    rst = 1'b0;
    exp_q.delete();
    repeat (6) begin
      cycle(1'b0, '0, '0, 1'b1, "no_stale", acc, pop);
      check("no_stale_valid", W'(valid_out), W'(0));
    end
    run_one("post_rst", 32'h0002_0000, 32'hFFFF_0000, 32'hFFFE_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
